dsu_command_sequencer: RTL

// Host-side sequencer for the core debug controller. It accepts debug commands from the

---
 rtl/dsu_command_sequencer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/dsu_command_sequencer.sv
`default_nettype none
// ============================================================================
// Module : dsu_command_sequencer
// Brief  : Host command sequencer for the core debug controller; one response
//          per accepted command.
// Rev    : 1.0
// ============================================================================
module dsu_command_sequencer #(
  parameter int BP_NUMB        = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int THREAD_NUMB    = 8,
  parameter int THREAD_ID_W    = (THREAD_NUMB > 1) ? $clog2(THREAD_NUMB) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cmd_valid_i,
  output logic                                   cmd_ready_o,
  input  logic [2:0]                             cmd_opcode_i,
  input  logic [2:0]                             cmd_index_i,
  input  logic [ADDR_WIDTH-1:0]                  cmd_data_i,
  output logic                                   rsp_valid_o,
  input  logic                                   rsp_ready_i,
  output logic [ADDR_WIDTH-1:0]                  rsp_data_o,
  output logic                                   rsp_error_o,
  output logic                                   dsu_enable_o,
  output logic                                   dsu_single_step_o,
  output logic                                   dsu_thread_selection_o,
  output logic [THREAD_ID_W-1:0]                 dsu_thread_id_o,
  output logic [BP_NUMB-1:0][ADDR_WIDTH-1:0]     dsu_breakpoint_o,
  output logic [BP_NUMB-1:0]                     dsu_breakpoint_enable_o,
  output logic                                   ext_freeze_o,
  output logic                                   resume_o,
  input  logic                                   freeze_i,
  input  logic                                   dsu_hit_breakpoint_i,
  input  logic [THREAD_ID_W-1:0]                 dsu_bp_thread_id_i,
  input  logic [THREAD_NUMB-1:0][ADDR_WIDTH-1:0] dsu_bp_instruction_i
);

  localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [2:0]       OP_NOP     = 3'd0;
  localparam logic [2:0]       OP_SET_BP  = 3'd1;
  localparam logic [2:0]       OP_EN_BP   = 3'd2;
  localparam logic [2:0]       OP_CONFIG  = 3'd3;
  localparam logic [2:0]       OP_HALT    = 3'd4;
  localparam logic [2:0]       OP_RESUME  = 3'd5;
  localparam logic [2:0]       OP_STATUS  = 3'd6;
  localparam logic [2:0]       OP_READ_PC = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_HALT_WAIT, S_RESUME_WAIT, S_RESP
  } state_e;

  state_e                             state_q, state_d;
  logic [2:0]                         op_q, op_d, idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]              data_q, data_d, rsp_data_q, rsp_data_d;
  logic                               rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               en_q, en_d, ss_q, ss_d, tsel_q, tsel_d;
  logic [THREAD_ID_W-1:0]             tid_q, tid_d;
  logic [BP_NUMB-1:0][ADDR_WIDTH-1:0] bp_q, bp_d;
  logic [BP_NUMB-1:0]                 bpen_q, bpen_d;
  logic                               sticky_q, sticky_d, resume_q, resume_d;
  logic                               sticky_clr;
  logic [31:0]                        idx_ext;
  logic [ADDR_WIDTH-1:0]              pc_sel, status;

  assign idx_ext = {29'd0, idx_q};

  always_comb begin
    pc_sel = '0;
    for (int i = 0; i < THREAD_NUMB; i++) begin
      if (idx_ext == 32'(i)) pc_sel = dsu_bp_instruction_i[i];
    end
    status                     = '0;
    status[8 +: THREAD_ID_W]   = dsu_bp_thread_id_i;
    status[3]                  = sticky_q;
    status[2]                  = dsu_hit_breakpoint_i;
    status[1]                  = en_q;
    status[0]                  = freeze_i;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    idx_d      = idx_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    en_d       = en_q;
    ss_d       = ss_q;
    tsel_d     = tsel_q;
    tid_d      = tid_q;
    bp_d       = bp_q;
    bpen_d     = bpen_q;
    resume_d   = 1'b0;
    sticky_clr = 1'b0;
    cnt_d      = (cnt_q == TIMEOUT) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d    = cmd_opcode_i;
          idx_d   = cmd_index_i;
          data_d  = cmd_data_i;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d    = S_RESP;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        case (op_q)
          OP_NOP: ;
          OP_SET_BP: begin
            if (idx_ext < 32'(BP_NUMB)) begin
              for (int i = 0; i < BP_NUMB; i++) begin
                if (idx_ext == 32'(i)) bp_d[i] = data_q;
              end
            end else begin
              rsp_err_d = 1'b1;
            end
          end
          OP_EN_BP:  bpen_d = data_q[BP_NUMB-1:0];
          OP_CONFIG: begin
            en_d   = data_q[0];
            ss_d   = data_q[1];
            tsel_d = data_q[2];
            tid_d  = data_q[8 +: THREAD_ID_W];
          end
          OP_HALT:   state_d = S_HALT_WAIT;
          OP_RESUME: begin
            if (freeze_i) begin
              resume_d   = 1'b1;
              sticky_clr = 1'b1;
              state_d    = S_RESUME_WAIT;
            end else begin
              rsp_err_d = 1'b1;
            end
          end
          OP_STATUS: rsp_data_d = status;
          OP_READ_PC: begin
            if (idx_ext < 32'(THREAD_NUMB)) rsp_data_d = pc_sel;
            else                            rsp_err_d  = 1'b1;
          end
          default: ;
        endcase
      end
      S_HALT_WAIT: begin
        if (freeze_i) begin
          state_d = S_RESP;
        end else if (cnt_q == TIMEOUT) begin
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESUME_WAIT: begin
        if (!freeze_i) begin
          state_d = S_RESP;
        end else if (cnt_q == TIMEOUT) begin
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A hit in the same cycle as the resume clear must not be lost.
    sticky_d = dsu_hit_breakpoint_i ? 1'b1 : (sticky_clr ? 1'b0 : sticky_q);
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      ss_q       <= 1'b0;
      tsel_q     <= 1'b0;
      tid_q      <= '0;
      bp_q       <= '0;
      bpen_q     <= '0;
      sticky_q   <= 1'b0;
      resume_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      ss_q       <= ss_d;
      tsel_q     <= tsel_d;
      tid_q      <= tid_d;
      bp_q       <= bp_d;
      bpen_q     <= bpen_d;
      sticky_q   <= sticky_d;
      resume_q   <= resume_d;
    end
  end

  assign cmd_ready_o             = (state_q == S_IDLE);
  assign rsp_valid_o             = (state_q == S_RESP);
  assign rsp_data_o              = rsp_data_q;
  assign rsp_error_o             = rsp_err_q;
  assign ext_freeze_o            = (state_q == S_HALT_WAIT);
  assign resume_o                = resume_q;
  assign dsu_enable_o            = en_q;
  assign dsu_single_step_o       = ss_q;
  assign dsu_thread_selection_o  = tsel_q;
  assign dsu_thread_id_o         = tid_q;
  assign dsu_breakpoint_o        = bp_q;
  assign dsu_breakpoint_enable_o = bpen_q;

endmodule
`default_nettype wire
